// File: rtl/decoder_out_packer.sv
// decoder_out_packer
//   Packs the serial decoded bit stream MSB-first into DATA_W-bit words,
//   buffers them in a small FIFO and presents them on a valid/ready port.
//   A falling edge of bit_valid ends a block. Any partial word is flushed
//   left-aligned, and the final word of the block carries m_last and its bit count.
// Ports:
//   clk, RSTn          clock, asynchronous active-low reset
//   bit_in, bit_valid  decoded bit and its qualifier (no backpressure)
//   m_data/m_last/m_nbits  head word, end-of-block flag, valid-bit count
//   m_valid, m_ready   output handshake
//   fifo_level         FIFO occupancy (writes - reads)
//   overflow           sticky word-dropped flag
module decoder_out_packer #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          RSTn,
  input  logic                          bit_in,
  input  logic                          bit_valid,
  output logic [DATA_W-1:0]             m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          m_last,
  output logic [$clog2(DATA_W):0]       m_nbits,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam int unsigned NB_W  = CNT_W + 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
    logic [NB_W-1:0]   nbits;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Bit packer state
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] r_sreg;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_bit_valid_d;
  logic              r_pend_v;
  logic [DATA_W-1:0] r_pend_data;

  logic [DATA_W-1:0] w_sreg_next;
  logic              w_complete;
  logic              w_partial;
  logic [NB_W-1:0]   w_shamt;
  logic [DATA_W-1:0] w_partial_data;

  // ---------------------------------------------------------------------------
  // FIFO state
  // ---------------------------------------------------------------------------
  entry_t            r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_count;
  logic              r_m_valid;
  logic [DATA_W-1:0] r_m_data;
  logic              r_m_last;
  logic [NB_W-1:0]   r_m_nbits;
  logic              r_overflow;

  logic              w_push;
  entry_t            w_push_entry;
  logic              w_pop;
  logic              w_full;
  logic              w_wr_en;
  logic              w_drop;
  logic [LVL_W-1:0]  w_visible;
  logic [PTR_W-1:0]  w_head_ptr;

  // Packer combinational terms
  always_comb begin
    w_sreg_next    = {r_sreg[DATA_W-2:0], bit_in};
    w_complete     = bit_valid && (r_cnt == CNT_W'(DATA_W - 1));
    // r_cnt is always 0 while a staged word is pending, so a partial flush
    // can never coincide with a staged push.
    w_partial      = !bit_valid && r_bit_valid_d && (r_cnt != '0);
    w_shamt        = NB_W'(DATA_W) - {1'b0, r_cnt};
    w_partial_data = r_sreg << w_shamt;
  end

  // Shift register, bit counter and one-entry staging register
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_sreg        <= '0;
      r_cnt         <= '0;
      r_bit_valid_d <= 1'b0;
      r_pend_v      <= 1'b0;
      r_pend_data   <= '0;
    end else begin
      r_bit_valid_d <= bit_valid;
      if (bit_valid) begin
        r_sreg <= w_sreg_next;
        r_cnt  <= w_complete ? '0 : r_cnt + CNT_W'(1);
      end else if (w_partial) begin
        r_cnt <= '0;
      end
      // A staged word is always pushed on the following cycle.
      r_pend_v <= w_complete;
      if (w_complete) begin
        r_pend_data <= w_sreg_next;
      end
    end
  end

  // FIFO write request: staged full word, or left-aligned partial word
  always_comb begin
    w_push       = 1'b0;
    w_push_entry = '0;
    if (r_pend_v) begin
      w_push             = 1'b1;
      w_push_entry.data  = r_pend_data;
      w_push_entry.last  = !bit_valid;
      w_push_entry.nbits = NB_W'(DATA_W);
    end else if (w_partial) begin
      w_push             = 1'b1;
      w_push_entry.data  = w_partial_data;
      w_push_entry.last  = 1'b1;
      w_push_entry.nbits = {1'b0, r_cnt};
    end
  end

  // FIFO control; a write into a full FIFO survives only alongside a pop
  always_comb begin
    w_pop      = r_m_valid && m_ready;
    w_full     = (r_count == LVL_W'(FIFO_DEPTH));
    w_wr_en    = w_push && (!w_full || w_pop);
    w_drop     = w_push && w_full && !w_pop;
    // Head candidates are only entries stored before this edge, so a new
    // word becomes visible one cycle after it is written.
    w_visible  = r_count - LVL_W'(w_pop);
    w_head_ptr = r_rd_ptr + PTR_W'(w_pop);
  end

  // FIFO storage (no reset needed; only read once written)
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= w_push_entry;
    end
  end

  // FIFO pointers, occupancy, registered head and sticky overflow
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_m_valid  <= 1'b0;
      r_m_data   <= '0;
      r_m_last   <= 1'b0;
      r_m_nbits  <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count   <= r_count + LVL_W'(w_wr_en) - LVL_W'(w_pop);
      r_m_valid <= (w_visible != '0);
      // Head fields hold their last value while the FIFO is empty.
      if (w_visible != '0) begin
        r_m_data  <= r_mem[w_head_ptr].data;
        r_m_last  <= r_mem[w_head_ptr].last;
        r_m_nbits <= r_mem[w_head_ptr].nbits;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign m_data     = r_m_data;
  assign m_valid    = r_m_valid;
  assign m_last     = r_m_last;
  assign m_nbits    = r_m_nbits;
  assign fifo_level = r_count;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_decoder_out_packer.sv
// Directed self-checking bench for decoder_out_packer (DATA_W=8, FIFO_DEPTH=4).
// Inputs change 1ns after the rising edge; outputs are sampled there as well,
// and handshakes are captured on the falling edge.
module tb_decoder_out_packer;

  logic       clk;
  logic       RSTn;
  logic       bit_in;
  logic       bit_valid;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;
  logic [3:0] m_nbits;
  logic [2:0] fifo_level;
  logic       overflow;

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0] cap_data[$];
  logic       cap_last[$];
  logic [3:0] cap_nb[$];
  logic [7:0] exp_data[$];
  logic       exp_last[$];
  logic [3:0] exp_nb[$];

  decoder_out_packer #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .RSTn       (RSTn),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .m_nbits    (m_nbits),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every accepted head word
  always @(negedge clk) begin
    if (RSTn && m_valid && m_ready) begin
      cap_data.push_back(m_data);
      cap_last.push_back(m_last);
      cap_nb.push_back(m_nbits);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    bit_in    = b;
    @(posedge clk);
    #1;
  endtask

  // Send the low n bits of d, MSB first
  task automatic send_word(input logic [15:0] d, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(d[i]);
  endtask

  task automatic idle(input int n);
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_word(input logic [7:0] d, input logic l, input logic [3:0] nb);
    exp_data.push_back(d);
    exp_last.push_back(l);
    exp_nb.push_back(nb);
  endtask

  task automatic compare_words(input string tag);
    int n;
    chk($sformatf("%s.count", tag), cap_data.size(), exp_data.size());
    n = (cap_data.size() < exp_data.size()) ? cap_data.size() : exp_data.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s[%0d].data", tag, i), cap_data[i], exp_data[i]);
      chk($sformatf("%s[%0d].last", tag, i), cap_last[i], exp_last[i]);
      chk($sformatf("%s[%0d].nbits", tag, i), cap_nb[i], exp_nb[i]);
    end
    cap_data.delete(); cap_last.delete(); cap_nb.delete();
    exp_data.delete(); exp_last.delete(); exp_nb.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".m_valid"},    m_valid,    0);
    chk({tag, ".m_data"},     m_data,     0);
    chk({tag, ".m_last"},     m_last,     0);
    chk({tag, ".m_nbits"},    m_nbits,    0);
    chk({tag, ".fifo_level"}, fifo_level, 0);
    chk({tag, ".overflow"},   overflow,   0);
  endtask

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RSTn      = 1'b0;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    m_ready   = 1'b0;
    #2;
    chk_reset_outputs("reset");
    @(posedge clk);
    #1;
    RSTn = 1'b1;
    idle(2);

    // T1: two back-to-back words with a two-cycle output latency
    m_ready = 1'b1;
    send_word(16'h00A5, 8);
    send_bit(1'b0);                    // bit 9 (0x3C MSB)
    chk("t1.lat1.m_valid", m_valid, 0);
    send_bit(1'b0);                    // bit 10
    chk("t1.lat2.m_valid", m_valid, 1);
    chk("t1.lat2.m_data",  m_data,  8'hA5);
    send_word(16'h003C, 6);            // remaining 6 bits: 111100
    idle(12);
    exp_word(8'hA5, 1'b0, 4'd8);
    exp_word(8'h3C, 1'b1, 4'd8);
    compare_words("t1");

    // T2: full word then 3-bit partial flush
    send_word(16'h00A5, 8);
    send_word(16'h0005, 3);
    idle(12);
    exp_word(8'hA5, 1'b0, 4'd8);
    exp_word(8'hA0, 1'b1, 4'd3);
    compare_words("t2");

    // T4: one-cycle gap splits the stream into two blocks
    send_word(16'h0016, 5);            // 10110
    idle(1);
    send_word(16'h00FF, 8);
    idle(12);
    exp_word(8'hB0, 1'b1, 4'd5);
    exp_word(8'hFF, 1'b1, 4'd8);
    compare_words("t4");

    // T5: full FIFO, pop coincides with the 5th word's push
    m_ready = 1'b0;
    send_word(16'h0011, 8);
    send_word(16'h0022, 8);
    send_word(16'h0033, 8);
    send_word(16'h0044, 8);
    send_word(16'h002A, 7);
    send_bit(1'b1);                    // completes 0x55
    chk("t5.full.level", fifo_level, 4);
    m_ready   = 1'b1;
    bit_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("t5.level",    fifo_level, 4);
    chk("t5.overflow", overflow,   0);
    chk("t5.m_data",   m_data,     8'h22);
    idle(12);
    exp_word(8'h11, 1'b0, 4'd8);
    exp_word(8'h22, 1'b0, 4'd8);
    exp_word(8'h33, 1'b0, 4'd8);
    exp_word(8'h44, 1'b0, 4'd8);
    exp_word(8'h55, 1'b1, 4'd8);
    compare_words("t5");

    // T3: no consumer, 5th word dropped
    m_ready = 1'b0;
    send_word(16'h0011, 8);
    send_word(16'h0022, 8);
    send_word(16'h0033, 8);
    send_word(16'h0044, 8);
    send_word(16'h0055, 8);
    idle(3);
    chk("t3.level",    fifo_level, 4);
    chk("t3.overflow", overflow,   1);
    chk("t3.m_valid",  m_valid,    1);
    chk("t3.m_data",   m_data,     8'h11);
    m_ready = 1'b1;
    idle(12);
    chk("t3.drain.level",    fifo_level, 0);
    chk("t3.drain.overflow", overflow,   1);
    exp_word(8'h11, 1'b0, 4'd8);
    exp_word(8'h22, 1'b0, 4'd8);
    exp_word(8'h33, 1'b0, 4'd8);
    exp_word(8'h44, 1'b0, 4'd8);
    compare_words("t3");

    // T6: reset mid-block discards partial bits and queued words
    m_ready = 1'b0;
    send_word(16'h0077, 8);
    idle(4);
    chk("t6.pre.m_valid", m_valid, 1);
    send_word(16'h0007, 3);
    bit_valid = 1'b0;
    RSTn      = 1'b0;
    #2;
    chk_reset_outputs("t6.rst");
    #1;
    RSTn = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_outputs("t6.post");
    m_ready = 1'b1;
    cap_data.delete(); cap_last.delete(); cap_nb.delete();
    send_word(16'h005A, 8);
    idle(12);
    exp_word(8'h5A, 1'b1, 4'd8);
    compare_words("t6");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/decoder_out_packer.md
# decoder_out_packer

Output packer placed directly downstream of the display-memory top (`mem_disp_top`) in the Viterbi decoder. It takes the serial decoded bit stream (`decoder_o_reg` qualified by `d_out_valid`) and packs it MSB-first into DATA_W-bit words. Words are buffered in a small FIFO and presented on a valid/ready output port. A falling edge of the input valid ends a block: any partial word is flushed, and the final word of the block is tagged with `m_last` and its valid-bit count.

## Interface
- DATA_W, 8, output word width (≥2).
- FIFO_DEPTH, 4, FIFO entries (power of 2, ≥2).
- clk  in  1  clock; all state on rising edge.
- RSTn  in  1  asynchronous active-low reset.
- bit_in  in  1  decoded bit (from `decoder_o_reg`).
- bit_valid  in  1  bit qualifier (from `d_out_valid`); sampled every cycle, no backpressure.
- m_data  out  DATA_W  packed word; first received bit in MSB.
- m_valid  out  1  FIFO head valid.
- m_ready  in  1  consumer accepts head when `m_valid & m_ready`.
- m_last  out  1  head is the final word of a block.
- m_nbits  out  $clog2(DATA_W)+1  number of valid bits in head, left-aligned (1..DATA_W).
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  sticky; a word was dropped because the FIFO was full.

## Operation
- Shift register `sreg[DATA_W-1:0]` and bit counter `cnt` (0..DATA_W-1); `bit_valid_d` is `bit_valid` registered.
- bit_valid=1: `sreg <= {sreg[DATA_W-2:0], bit_in}`; `cnt` increments and wraps DATA_W-1 → 0.
- Word completion (bit_valid=1 and cnt=DATA_W-1): the completed word is loaded into a one-entry staging register (`pend_v`=1).
- Cycle after completion, exactly one of:
  - bit_valid=1: push staged word with last=0, nbits=DATA_W.
  - bit_valid=0: push staged word with last=1, nbits=DATA_W.
  - In both cases `pend_v` clears.
- Fall with partial word (bit_valid=0, bit_valid_d=1, cnt≠0): push `{sreg[cnt-1:0], zeros}` left-aligned, last=1, nbits=cnt; `cnt` ← 0.
- The staged push and the partial push are mutually exclusive by construction: `cnt`=0 whenever `pend_v`=1. At most one FIFO write occurs per cycle.
- Any 0-cycle of bit_valid after a 1 ends the block. A one-cycle gap therefore splits the stream into two blocks.
- FIFO write when full:
  - If the same cycle pops (`m_valid & m_ready`), the write is accepted.
  - Otherwise the word is dropped and `overflow` ← 1; `overflow` clears only on reset.
- FIFO entry holds {data, last, nbits}. `m_data`, `m_last` and `m_nbits` show the head entry. When empty they hold their last value and are don't-care.
- `fifo_level` = writes − reads, in the range 0..FIFO_DEPTH.

## Timing
- Reset (async assert, sync use after release) values:
  - `m_valid`=0, `m_data`=0, `m_last`=0, `m_nbits`=0, `fifo_level`=0, `overflow`=0.
  - Internal state cleared: `cnt`=0, `pend_v`=0, `bit_valid_d`=0.
- Latency: DATA_W-th bit sampled at edge t. FIFO write at edge t+1. `m_valid`=1 after edge t+2 if the FIFO was empty.
- Partial flush: fall detected at edge t (bit_valid=0 sampled). FIFO write at edge t. `m_valid` after edge t+1.
- Pop: head advances on the edge where `m_valid & m_ready`=1. A simultaneous push and pop leaves `fifo_level` unchanged.
- Reset mid-block: partial word, staged word and FIFO contents are all discarded.

## Test plan
- Continuous 16 bits 0xA5 then 0x3C, then bit_valid=0, m_ready=1 → words 0xA5 (last=0, nbits=8) and 0x3C (last=1, nbits=8); `m_valid` first high 2 cycles after 8th bit.
- 11 bits 0xA5 then 101, then fall → 0xA5 (last=0), then 0xA0 (last=1, nbits=3).
- m_ready=0, 40 continuous bits → `fifo_level`=4, 5th word dropped, `overflow`=1; drain returns the first 4 words in order.
- 5 bits 10110, one-cycle gap, 8 bits 0xFF, fall → 0xB0 (nbits=5, last=1), then 0xFF (nbits=8, last=1).
- Full FIFO with m_ready=1 on the same cycle as the 5th word's push → no drop, `overflow`=0, `fifo_level` stays 4.
- RSTn pulsed low after 3 bits of a word → all outputs at reset values; following 8 bits 0x5A produce a single word 0x5A (last=1, nbits=8).
